// File: rtl/regfile_conv3_pkg.sv
// Shared widths and types for the register file and its 3-tap convolution consumer.
package regfile_conv3_pkg;

    localparam int unsigned AddrSize = 7;
    localparam int unsigned DataSize = 32;
    localparam int unsigned RegSize  = 128;
    localparam int unsigned CoefSize = 8;
    localparam int unsigned OutSize  = DataSize + CoefSize + 2;

    typedef logic [AddrSize-1:0] addr_t;
    typedef logic [AddrSize:0]   len_t;
    typedef logic [DataSize-1:0] data_t;
    typedef logic [CoefSize-1:0] coef_t;
    typedef logic [OutSize-1:0]  out_t;

    // Window address, wrapping modulo the register file size.
    function automatic addr_t wrap_addr(addr_t base, len_t off);
        return addr_t'(base + addr_t'(off));
    endfunction

endpackage

// File: rtl/regfile_conv3_if.sv
// Register file read port plus result stream handshake.
interface regfile_conv3_if;
    import regfile_conv3_pkg::*;

    logic  reg_enable;
    logic  reg_write;
    addr_t src_addr;
    data_t src1;
    data_t src2;
    data_t src3;
    out_t  out_data;
    logic  out_valid;
    logic  out_ready;

    modport master (
        output reg_enable, reg_write, src_addr, out_data, out_valid,
        input  src1, src2, src3, out_ready
    );

    modport slave (
        input  reg_enable, reg_write, src_addr, out_data, out_valid,
        output src1, src2, src3, out_ready
    );

endinterface

// File: rtl/regfile_conv3_mac.sv
// Combinational 3-tap multiply-accumulate, exact to OutSize bits.
module regfile_conv3_mac
    import regfile_conv3_pkg::*;
(
    input  coef_t coef0,
    input  coef_t coef1,
    input  coef_t coef2,
    input  data_t src1,
    input  data_t src2,
    input  data_t src3,
    output out_t  sum
);

    localparam int unsigned ProdSize = CoefSize + DataSize;

    logic [ProdSize-1:0] prod0;
    logic [ProdSize-1:0] prod1;
    logic [ProdSize-1:0] prod2;

    always_comb begin
        prod0 = {{DataSize{1'b0}}, coef0} * {{CoefSize{1'b0}}, src1};
        prod1 = {{DataSize{1'b0}}, coef1} * {{CoefSize{1'b0}}, src2};
        prod2 = {{DataSize{1'b0}}, coef2} * {{CoefSize{1'b0}}, src3};
        sum   = out_t'(prod0) + out_t'(prod1) + out_t'(prod2);
    end

endmodule

// File: rtl/regfile_conv3.sv
// Sweeps the register file in 3-word windows and streams one weighted sum per window.
module regfile_conv3
    import regfile_conv3_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  addr_t            base_addr,
    input  len_t             length,
    input  coef_t            coef0,
    input  coef_t            coef1,
    input  coef_t            coef2,
    regfile_conv3_if.master  bus,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {StIdle, StRead, StCap, StOut, StFin} state_e;

    state_e state_q;
    addr_t  base_q;
    len_t   len_q;
    len_t   k_q;
    len_t   k_next;
    coef_t  c0_q;
    coef_t  c1_q;
    coef_t  c2_q;
    addr_t  addr_q;
    out_t   data_q;
    out_t   mac_sum;
    logic   reg_en_q;
    logic   valid_q;
    logic   busy_q;
    logic   done_q;

    regfile_conv3_mac u_mac (
        .coef0 (c0_q),
        .coef1 (c1_q),
        .coef2 (c2_q),
        .src1  (bus.src1),
        .src2  (bus.src2),
        .src3  (bus.src3),
        .sum   (mac_sum)
    );

    assign k_next = k_q + len_t'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            base_q   <= '0;
            len_q    <= '0;
            k_q      <= '0;
            c0_q     <= '0;
            c1_q     <= '0;
            c2_q     <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            reg_en_q <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            reg_en_q <= 1'b0;
            done_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        base_q <= base_addr;
                        len_q  <= length;
                        c0_q   <= coef0;
                        c1_q   <= coef1;
                        c2_q   <= coef2;
                        k_q    <= '0;
                        busy_q <= 1'b1;
                        if (length == '0) begin
                            state_q <= StFin;
                        end else begin
                            state_q  <= StRead;
                            reg_en_q <= 1'b1;
                            addr_q   <= base_addr;
                        end
                    end
                end
                StRead: state_q <= StCap;
                StCap: begin
                    data_q  <= mac_sum;
                    valid_q <= 1'b1;
                    state_q <= StOut;
                end
                StOut: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        k_q     <= k_next;
                        if (k_next == len_q) begin
                            state_q <= StFin;
                        end else begin
                            state_q  <= StRead;
                            reg_en_q <= 1'b1;
                            addr_q   <= wrap_addr(base_q, k_next);
                        end
                    end
                end
                StFin: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.reg_enable = reg_en_q;
    assign bus.reg_write  = 1'b0;
    assign bus.src_addr   = addr_q;
    assign bus.out_data   = data_q;
    assign bus.out_valid  = valid_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_regfile_conv3.sv
// Directed bench for regfile_conv3 with a behavioural 1-cycle-latency register file.
module tb_regfile_conv3;
    import regfile_conv3_pkg::*;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    logic  start = 1'b0;
    addr_t base_addr = '0;
    len_t  length = '0;
    coef_t coef0 = '0;
    coef_t coef1 = '0;
    coef_t coef2 = '0;
    logic  busy;
    logic  done;

    regfile_conv3_if bus ();

    regfile_conv3 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .coef0     (coef0),
        .coef1     (coef1),
        .coef2     (coef2),
        .bus       (bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    data_t mem [RegSize];

    always @(posedge clk) begin
        if (bus.reg_enable) begin
            bus.src1 <= mem[bus.src_addr];
            bus.src2 <= mem[addr_t'(bus.src_addr + addr_t'(1))];
            bus.src3 <= mem[addr_t'(bus.src_addr + addr_t'(2))];
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    always @(negedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input addr_t b, input len_t l, input coef_t a0, input coef_t a1,
                            input coef_t a2);
        base_addr = b;
        length    = l;
        coef0     = a0;
        coef1     = a1;
        coef2     = a2;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int i = 0;
        while (!bus.out_valid && i < 20) begin
            tick();
            i++;
        end
        if (!bus.out_valid) check({tag, "_timeout"}, 64'(bus.out_valid), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        int i = 0;
        while (!done && i < 20) begin
            tick();
            i++;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        tick();
    endtask

    task automatic load_ramp();
        for (int unsigned i = 0; i < 5; i++) mem[i] = 32'hffff_0000 + i;
    endtask

    int d0;

    initial begin
        for (int unsigned i = 0; i < RegSize; i++) mem[i] = '0;
        bus.out_ready = 1'b1;

        // Reset state
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_ren", 64'(bus.reg_enable), 64'd0);
        check("rst_rwr", 64'(bus.reg_write), 64'd0);
        check("rst_addr", 64'(bus.src_addr), 64'd0);
        check("rst_data", 64'(bus.out_data), 64'd0);
        rst = 1'b1;
        tick();

        // Basic sweep, latency and done pulse
        load_ramp();
        d0 = done_cnt;
        do_start(7'd0, 8'd3, 8'd1, 8'd2, 8'd1);
        check("t1_ren", 64'(bus.reg_enable), 64'd1);
        check("t1_addr", 64'(bus.src_addr), 64'd0);
        check("t1_busy", 64'(busy), 64'd1);
        tick();
        check("t1_lat2", 64'(bus.out_valid), 64'd0);
        tick();
        check("t1_lat3", 64'(bus.out_valid), 64'd1);
        check("t1_r0", 64'(bus.out_data), 64'h3_FFFC_0004);
        check("t1_rwr", 64'(bus.reg_write), 64'd0);
        tick();
        check("t1_vdrop", 64'(bus.out_valid), 64'd0);
        wait_valid("t1_r1");
        check("t1_r1", 64'(bus.out_data), 64'h3_FFFC_0008);
        tick();
        wait_valid("t1_r2");
        check("t1_r2", 64'(bus.out_data), 64'h3_FFFC_000C);
        tick();
        check("t1_fin_done", 64'(done), 64'd0);
        tick();
        check("t1_done", 64'(done), 64'd1);
        tick();
        check("t1_done_low", 64'(done), 64'd0);
        check("t1_idle", 64'(busy), 64'd0);
        check("t1_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Backpressure on the second result
        d0 = done_cnt;
        do_start(7'd0, 8'd3, 8'd1, 8'd2, 8'd1);
        wait_valid("bp_r0");
        check("bp_r0", 64'(bus.out_data), 64'h3_FFFC_0004);
        tick();
        wait_valid("bp_r1");
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", 64'(bus.out_valid), 64'd1);
            check("bp_data", 64'(bus.out_data), 64'h3_FFFC_0008);
            check("bp_addr", 64'(bus.src_addr), 64'd1);
            check("bp_ren", 64'(bus.reg_enable), 64'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        wait_valid("bp_r2");
        check("bp_r2", 64'(bus.out_data), 64'h3_FFFC_000C);
        tick();
        wait_done("bp");
        check("bp_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Start pulsed mid-sweep is ignored
        d0 = done_cnt;
        do_start(7'd0, 8'd3, 8'd1, 8'd2, 8'd1);
        base_addr = 7'd10;
        length    = 8'd1;
        coef0     = 8'd9;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        wait_valid("ms_r0");
        check("ms_r0", 64'(bus.out_data), 64'h3_FFFC_0004);
        tick();
        wait_valid("ms_r1");
        check("ms_r1", 64'(bus.out_data), 64'h3_FFFC_0008);
        tick();
        wait_valid("ms_r2");
        check("ms_r2", 64'(bus.out_data), 64'h3_FFFC_000C);
        tick();
        wait_done("ms");
        check("ms_idle", 64'(busy), 64'd0);
        check("ms_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Address wrap
        mem[126] = 32'd10;
        mem[127] = 32'd20;
        mem[0]   = 32'hffff_0000;
        do_start(7'd126, 8'd1, 8'd1, 8'd1, 8'd1);
        check("wr_addr", 64'(bus.src_addr), 64'd126);
        wait_valid("wr");
        check("wr_data", 64'(bus.out_data), 64'h0_FFFF_001E);
        tick();
        wait_done("wr");

        // Maximum operands
        for (int unsigned i = 0; i < 3; i++) mem[i] = 32'hffff_ffff;
        do_start(7'd0, 8'd1, 8'd255, 8'd255, 8'd255);
        wait_valid("mx");
        check("mx_data", 64'(bus.out_data), 64'h2FC_FFFF_FD03);
        tick();
        wait_done("mx");

        // Zero-length start
        d0 = done_cnt;
        do_start(7'd50, 8'd0, 8'd1, 8'd1, 8'd1);
        check("z_done1", 64'(done), 64'd0);
        check("z_valid1", 64'(bus.out_valid), 64'd0);
        check("z_ren", 64'(bus.reg_enable), 64'd0);
        tick();
        check("z_done2", 64'(done), 64'd1);
        check("z_valid2", 64'(bus.out_valid), 64'd0);
        tick();
        check("z_done3", 64'(done), 64'd0);
        check("z_done_cnt", 64'(done_cnt - d0), 64'd1);

        // Reset while holding a result in OUT
        load_ramp();
        d0 = done_cnt;
        bus.out_ready = 1'b0;
        do_start(7'd0, 8'd3, 8'd1, 8'd2, 8'd1);
        wait_valid("rs");
        check("rs_pre_busy", 64'(busy), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("rs_busy", 64'(busy), 64'd0);
        check("rs_valid", 64'(bus.out_valid), 64'd0);
        check("rs_ren", 64'(bus.reg_enable), 64'd0);
        check("rs_data", 64'(bus.out_data), 64'd0);
        tick();
        tick();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        check("rs_no_done", 64'(done_cnt - d0), 64'd0);
        mem[126] = 32'd10;
        mem[127] = 32'd20;
        do_start(7'd126, 8'd1, 8'd1, 8'd1, 8'd1);
        wait_valid("rs_after");
        check("rs_after_data", 64'(bus.out_data), 64'h0_FFFF_001E);
        tick();
        wait_done("rs_after");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
